// File: rtl/sap_ctrl_pkg.sv
// Shared definitions for the SAP control sequencer: T-state encodings, opcodes
// and control-word bit positions used by the datapath integration.
package sap_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_TR   = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4,
        ST_T5   = 3'd5,
        ST_T6   = 3'd6,
        ST_HALT = 3'd7
    } state_t;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_STA = 4'h3;
    localparam logic [3:0] OP_LDI = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h5;
    localparam logic [3:0] OP_JC  = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int CW_W   = 16;
    localparam int CW_LP  = 0;
    localparam int CW_CP  = 1;
    localparam int CW_EP  = 2;
    localparam int CW_LM  = 3;
    localparam int CW_CE  = 4;
    localparam int CW_RI  = 5;
    localparam int CW_LI  = 6;
    localparam int CW_EI  = 7;
    localparam int CW_LA  = 8;
    localparam int CW_EA  = 9;
    localparam int CW_LB  = 10;
    localparam int CW_EU  = 11;
    localparam int CW_SU  = 12;
    localparam int CW_FI  = 13;
    localparam int CW_LO  = 14;
    localparam int CW_HLT = 15;

    typedef logic [CW_W-1:0] cw_t;

endpackage

// File: rtl/sap_ctrl_decode.sv
// Combinational microcode: maps (T-state, opcode, flags) to the control word and
// flags the last T-state of the instruction, where ep is issued for the next fetch.
module sap_ctrl_decode
    import sap_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [3:0] opcode,
    input  logic       carry,
    input  logic       zero,
    output cw_t        cw,
    output logic       last
);

    always_comb begin
        cw   = '0;
        last = 1'b0;
        case (state)
            ST_TR: last = 1'b1;
            ST_T1: cw[CW_LM] = 1'b1;
            ST_T2: cw[CW_CP] = 1'b1;
            ST_T3: begin
                cw[CW_CE] = 1'b1;
                cw[CW_LI] = 1'b1;
            end
            ST_T4: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        cw[CW_EI] = 1'b1;
                        cw[CW_LM] = 1'b1;
                    end
                    OP_LDI: begin
                        cw[CW_EI] = 1'b1;
                        cw[CW_LA] = 1'b1;
                        last      = 1'b1;
                    end
                    OP_JMP: begin
                        cw[CW_EI] = 1'b1;
                        cw[CW_LP] = 1'b1;
                        last      = 1'b1;
                    end
                    // Conditional jumps only look at the flags here, in T4
                    OP_JC: begin
                        cw[CW_EI] = carry;
                        cw[CW_LP] = carry;
                        last      = 1'b1;
                    end
                    OP_JZ: begin
                        cw[CW_EI] = zero;
                        cw[CW_LP] = zero;
                        last      = 1'b1;
                    end
                    OP_OUT: begin
                        cw[CW_EA] = 1'b1;
                        cw[CW_LO] = 1'b1;
                        last      = 1'b1;
                    end
                    OP_HLT: cw[CW_HLT] = 1'b1;
                    default: last = 1'b1;
                endcase
            end
            ST_T5: begin
                case (opcode)
                    OP_LDA: begin
                        cw[CW_CE] = 1'b1;
                        cw[CW_LA] = 1'b1;
                        last      = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        cw[CW_CE] = 1'b1;
                        cw[CW_LB] = 1'b1;
                    end
                    OP_STA: begin
                        cw[CW_EA] = 1'b1;
                        cw[CW_RI] = 1'b1;
                        last      = 1'b1;
                    end
                    default: last = 1'b1;
                endcase
            end
            ST_T6: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    cw[CW_EU] = 1'b1;
                    cw[CW_LA] = 1'b1;
                    cw[CW_FI] = 1'b1;
                    cw[CW_SU] = (opcode == OP_SUB);
                end
                last = 1'b1;
            end
            ST_HALT: cw[CW_HLT] = 1'b1;
            default: cw = '0;
        endcase
        // ep leads T1 by one cycle because the PC registers its output enable
        if (last) begin
            cw[CW_EP] = 1'b1;
        end
    end

endmodule

// File: rtl/sap_controller_sequencer.sv
// SAP control sequencer: T-state register and next-state logic around the
// microcode decoder; outputs are forced low while rst is high.
module sap_controller_sequencer
    import sap_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int LAST_T   = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                carry,
    input  logic                zero,
    output logic                clr_n,
    output logic                lp,
    output logic                cp,
    output logic                ep,
    output logic                lm,
    output logic                ce,
    output logic                ri,
    output logic                li,
    output logic                ei,
    output logic                la,
    output logic                ea,
    output logic                lb,
    output logic                eu,
    output logic                su,
    output logic                fi,
    output logic                lo,
    output logic                hlt
);

    localparam state_t LAST_STATE = state_t'(3'(LAST_T));

    state_t state_reg;
    state_t state_next;
    cw_t    cw_raw;
    cw_t    cw_out;
    logic   last;

    sap_ctrl_decode u_decode (
        .state  (state_reg),
        .opcode (opcode[3:0]),
        .carry  (carry),
        .zero   (zero),
        .cw     (cw_raw),
        .last   (last)
    );

    always_comb begin
        state_next = ST_TR;
        case (state_reg)
            ST_HALT: state_next = ST_HALT;
            ST_TR, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6: begin
                if (cw_raw[CW_HLT]) begin
                    state_next = ST_HALT;
                end else if (last) begin
                    state_next = ST_T1;
                end else if (state_reg >= LAST_STATE) begin
                    // Guard: an execute phase that runs past its final T-state restarts cleanly
                    state_next = ST_TR;
                end else begin
                    state_next = state_t'(state_reg + 3'd1);
                end
            end
            default: state_next = ST_TR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_TR;
        end else begin
            state_reg <= state_next;
        end
    end

    for (genvar gi = 0; gi < CW_W; gi++) begin : g_gate
        assign cw_out[gi] = cw_raw[gi] & ~rst;
    end

    assign clr_n = ~rst;
    assign lp    = cw_out[CW_LP];
    assign cp    = cw_out[CW_CP];
    assign ep    = cw_out[CW_EP];
    assign lm    = cw_out[CW_LM];
    assign ce    = cw_out[CW_CE];
    assign ri    = cw_out[CW_RI];
    assign li    = cw_out[CW_LI];
    assign ei    = cw_out[CW_EI];
    assign la    = cw_out[CW_LA];
    assign ea    = cw_out[CW_EA];
    assign lb    = cw_out[CW_LB];
    assign eu    = cw_out[CW_EU];
    assign su    = cw_out[CW_SU];
    assign fi    = cw_out[CW_FI];
    assign lo    = cw_out[CW_LO];
    assign hlt   = cw_out[CW_HLT];

endmodule

// File: tb/tb_sap_controller_sequencer.sv
// Directed table plus hand-written sequences and a random instruction stream
// for the SAP control sequencer.
module tb_sap_controller_sequencer;

    localparam logic [15:0] M_LP  = 16'h8000;
    localparam logic [15:0] M_CP  = 16'h4000;
    localparam logic [15:0] M_EP  = 16'h2000;
    localparam logic [15:0] M_LM  = 16'h1000;
    localparam logic [15:0] M_CE  = 16'h0800;
    localparam logic [15:0] M_RI  = 16'h0400;
    localparam logic [15:0] M_LI  = 16'h0200;
    localparam logic [15:0] M_EI  = 16'h0100;
    localparam logic [15:0] M_LA  = 16'h0080;
    localparam logic [15:0] M_EA  = 16'h0040;
    localparam logic [15:0] M_LB  = 16'h0020;
    localparam logic [15:0] M_EU  = 16'h0010;
    localparam logic [15:0] M_SU  = 16'h0008;
    localparam logic [15:0] M_FI  = 16'h0004;
    localparam logic [15:0] M_LO  = 16'h0002;
    localparam logic [15:0] M_HLT = 16'h0001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] opcode = 4'h0;
    logic       carry = 1'b0;
    logic       zero = 1'b0;
    logic       clr_n, lp, cp, ep, lm, ce, ri, li, ei, la, ea, lb, eu, su, fi, lo, hlt;
    logic [15:0] obs;
    logic       ep_d = 1'b0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  op;
        logic        c;
        logic        z;
        logic [15:0] exp;
        logic        clrn;
        int          tid;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    sap_controller_sequencer dut (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .carry  (carry),
        .zero   (zero),
        .clr_n  (clr_n),
        .lp     (lp),
        .cp     (cp),
        .ep     (ep),
        .lm     (lm),
        .ce     (ce),
        .ri     (ri),
        .li     (li),
        .ei     (ei),
        .la     (la),
        .ea     (ea),
        .lb     (lb),
        .eu     (eu),
        .su     (su),
        .fi     (fi),
        .lo     (lo),
        .hlt    (hlt)
    );

    assign obs = {lp, cp, ep, lm, ce, ri, li, ei, la, ea, lb, eu, su, fi, lo, hlt};

    always @(posedge clk) ep_d <= ep;

    // Bus-driver exclusivity and mutual-exclusion rules, checked every cycle
    always @(negedge clk) begin
        checks++;
        if ($countones({ce, ei, ea, eu, ep_d}) > 1 || (lp && cp) || (ri && ce)) begin
            failures++;
            $display("FAIL excl: ce=%b ei=%b ea=%b eu=%b ep_d=%b lp=%b cp=%b ri=%b, required at most one driver, lp&cp=0, ri&ce=0",
                     ce, ei, ea, eu, ep_d, lp, cp, ri);
        end
    end

    task automatic add(int t, logic r, logic [3:0] op, logic c, logic z, logic [15:0] e);
        vecs.push_back('{r, op, c, z, e, ~r, t});
    endtask

    task automatic add_fetch(int t, logic [3:0] op, logic c, logic z);
        add(t, 1'b0, op, c, z, M_LM);
        add(t, 1'b0, op, c, z, M_CP);
        add(t, 1'b0, op, c, z, M_CE | M_LI);
    endtask

    // Drive one cycle of inputs, then sample on the falling edge
    task automatic drive(logic r, logic [3:0] op, logic c, logic z);
        rst = r;
        opcode = op;
        carry = c;
        zero = z;
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [15:0] exp, logic exp_clrn);
        checks++;
        if (obs !== exp || clr_n !== exp_clrn) begin
            failures++;
            $display("FAIL %s: got cw=%04h clr_n=%b, required cw=%04h clr_n=%b", name, obs, clr_n, exp, exp_clrn);
        end else begin
            $display("%s: cw=%04h clr_n=%b ok", name, obs, clr_n);
        end
    endtask

    function automatic int exp_len(logic [3:0] op);
        case (op)
            4'h0, 4'h3: return 5;
            4'h1, 4'h2: return 6;
            default:    return 4;
        endcase
    endfunction

    initial begin
        // Test 1: reset, then LDA
        add(1, 1'b1, 4'h0, 1'b0, 1'b0, 16'h0000);
        add(1, 1'b1, 4'h0, 1'b0, 1'b0, 16'h0000);
        add(1, 1'b0, 4'h0, 1'b0, 1'b0, M_EP);
        add_fetch(1, 4'h0, 1'b0, 1'b0);
        add(1, 1'b0, 4'h0, 1'b0, 1'b0, M_EI | M_LM);
        add(1, 1'b0, 4'h0, 1'b0, 1'b0, M_CE | M_LA | M_EP);
        // Test 2: ADD then SUB
        add_fetch(2, 4'h1, 1'b0, 1'b0);
        add(2, 1'b0, 4'h1, 1'b0, 1'b0, M_EI | M_LM);
        add(2, 1'b0, 4'h1, 1'b0, 1'b0, M_CE | M_LB);
        add(2, 1'b0, 4'h1, 1'b0, 1'b0, M_EU | M_LA | M_FI | M_EP);
        add_fetch(2, 4'h2, 1'b0, 1'b0);
        add(2, 1'b0, 4'h2, 1'b0, 1'b0, M_EI | M_LM);
        add(2, 1'b0, 4'h2, 1'b0, 1'b0, M_CE | M_LB);
        add(2, 1'b0, 4'h2, 1'b0, 1'b0, M_EU | M_LA | M_FI | M_SU | M_EP);
        // Test 3: conditional jumps, and flags outside T4 ignored
        add_fetch(3, 4'h6, 1'b1, 1'b0);
        add(3, 1'b0, 4'h6, 1'b1, 1'b0, M_EI | M_LP | M_EP);
        add_fetch(3, 4'h6, 1'b1, 1'b1);
        add(3, 1'b0, 4'h6, 1'b0, 1'b1, M_EP);
        add_fetch(3, 4'h7, 1'b0, 1'b0);
        add(3, 1'b0, 4'h7, 1'b0, 1'b1, M_EI | M_LP | M_EP);
        add_fetch(3, 4'h7, 1'b1, 1'b1);
        add(3, 1'b0, 4'h7, 1'b1, 1'b0, M_EP);
        add_fetch(3, 4'h1, 1'b0, 1'b0);
        add(3, 1'b0, 4'h1, 1'b0, 1'b0, M_EI | M_LM);
        add(3, 1'b0, 4'h1, 1'b1, 1'b1, M_CE | M_LB);
        add(3, 1'b0, 4'h1, 1'b0, 1'b1, M_EU | M_LA | M_FI | M_EP);
        add_fetch(3, 4'h5, 1'b0, 1'b0);
        add(3, 1'b0, 4'h5, 1'b0, 1'b0, M_EI | M_LP | M_EP);
        // Remaining opcodes: STA, LDI, OUT, NOP
        add_fetch(3, 4'h3, 1'b0, 1'b0);
        add(3, 1'b0, 4'h3, 1'b0, 1'b0, M_EI | M_LM);
        add(3, 1'b0, 4'h3, 1'b0, 1'b0, M_EA | M_RI | M_EP);
        add_fetch(3, 4'h4, 1'b0, 1'b0);
        add(3, 1'b0, 4'h4, 1'b0, 1'b0, M_EI | M_LA | M_EP);
        add_fetch(3, 4'hE, 1'b0, 1'b0);
        add(3, 1'b0, 4'hE, 1'b0, 1'b0, M_EA | M_LO | M_EP);
        add_fetch(3, 4'hB, 1'b1, 1'b1);
        add(3, 1'b0, 4'hB, 1'b1, 1'b1, M_EP);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].op, vecs[i].c, vecs[i].z);
            chk($sformatf("t%0d_vec%0d", vecs[i].tid, i), vecs[i].exp, vecs[i].clrn);
            advance();
        end

        // Test 4: HLT, hold, then reset
        drive(1'b0, 4'hF, 1'b0, 1'b0); chk("t4_t1", M_LM, 1'b1); advance();
        drive(1'b0, 4'hF, 1'b0, 1'b0); chk("t4_t2", M_CP, 1'b1); advance();
        drive(1'b0, 4'hF, 1'b0, 1'b0); chk("t4_t3", M_CE | M_LI, 1'b1); advance();
        drive(1'b0, 4'hF, 1'b0, 1'b0); chk("t4_t4", M_HLT, 1'b1); advance();
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
            chk($sformatf("t4_halt%0d", i), M_HLT, 1'b1);
            advance();
        end
        drive(1'b1, 4'h0, 1'b0, 1'b0); chk("t4_rst", 16'h0000, 1'b0); advance();
        drive(1'b0, 4'h1, 1'b0, 1'b0); chk("t4_tr", M_EP, 1'b1); advance();

        // Test 5: reset in T5 of ADD
        drive(1'b0, 4'h1, 1'b0, 1'b0); chk("t5_t1", M_LM, 1'b1); advance();
        drive(1'b0, 4'h1, 1'b0, 1'b0); chk("t5_t2", M_CP, 1'b1); advance();
        drive(1'b0, 4'h1, 1'b0, 1'b0); chk("t5_t3", M_CE | M_LI, 1'b1); advance();
        drive(1'b0, 4'h1, 1'b0, 1'b0); chk("t5_t4", M_EI | M_LM, 1'b1); advance();
        drive(1'b1, 4'h1, 1'b0, 1'b0); chk("t5_rst_t5", 16'h0000, 1'b0); advance();
        drive(1'b1, 4'h1, 1'b0, 1'b0); chk("t5_rst_hold", 16'h0000, 1'b0); advance();
        drive(1'b0, 4'h1, 1'b0, 1'b0); chk("t5_tr", M_EP, 1'b1); advance();

        // Test 6: random instruction stream, cycle counts per opcode
        for (int k = 0; k < 1000; k++) begin
            logic [3:0] op;
            logic       c;
            logic       z;
            logic       exp_lp;
            int         n;
            op = 4'($urandom_range(14, 0));
            n = 0;
            while (1) begin
                c = 1'($urandom_range(1, 0));
                z = 1'($urandom_range(1, 0));
                drive(1'b0, op, c, z);
                n++;
                if (n == 4 && (op == 4'h5 || op == 4'h6 || op == 4'h7)) begin
                    exp_lp = (op == 4'h5) || (op == 4'h6 && c) || (op == 4'h7 && z);
                    checks++;
                    if (lp !== exp_lp) begin
                        failures++;
                        $display("FAIL rnd%0d_lp: op=%h c=%b z=%b got lp=%b, required lp=%b", k, op, c, z, lp, exp_lp);
                    end
                end
                if (ep === 1'b1 || n >= 8) begin
                    advance();
                    break;
                end
                advance();
            end
            checks++;
            if (n != exp_len(op)) begin
                failures++;
                $display("FAIL rnd%0d_len: op=%h got %0d cycles, required %0d", k, op, n, exp_len(op));
            end else begin
                $display("rnd%0d: op=%h len=%0d ok", k, op, n);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
